// File: rtl/key_expander.sv
// rtl/key_expander.sv - AES-128 key schedule engine with random-access round-key table
// Optional KEY_CACHE_EN: skip re-expansion when the requested key matches the last expanded one.

module aes_sbox (
  input  logic [7:0] byte_val,
  output logic [7:0] sub_val
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sub_val = SBOX[byte_val];

endmodule

module key_expander #(
  parameter int NROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_key_exp,
  input  logic [127:0] key_in,
  input  logic [3:0]   rk_sel,
  output logic [127:0] rk_out,
  output logic         key_expanded,
  output logic         rk_valid,
  output logic         busy
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] EXPAND   = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [1:0] WAIT_LOW = 2'd3;

  logic [1:0]   state;
  logic [3:0]   round;
  logic [127:0] rk [0:NROUNDS];
  logic [3:0]   prev_idx;
  logic [127:0] prev;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rcon;
  logic         last_round;
  logic         cache_hit;

  assign prev_idx   = (round == 4'd0) ? 4'd0 : round - 4'd1;
  assign prev       = rk[prev_idx];
  assign {w0, w1, w2, w3} = prev;
  assign rot        = {w3[23:0], w3[31:24]};
  assign last_round = (round == 4'(NROUNDS));

  always_comb begin
    rcon = 8'h00;
    case (round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_val(rot[8*i +: 8]),
      .sub_val (sub[8*i +: 8])
    );
  end

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

`ifdef KEY_CACHE_EN
  logic [127:0] cache_key;

  // rk_valid gates the hit so a cleared (zero) cache never matches an all-zero key
  assign cache_hit = rk_valid && (key_in == cache_key);

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_key <= '0;
    end else if (state == EXPAND) begin
      if (!start_key_exp)
        cache_key <= '0;
      else if (last_round)
        cache_key <= rk[0];
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      round    <= 4'd0;
      rk_valid <= 1'b0;
      for (int i = 0; i <= NROUNDS; i++)
        rk[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_key_exp) begin
            if (cache_hit) begin
              state <= DONE;
            end else begin
              rk[0]    <= key_in;
              round    <= 4'd1;
              rk_valid <= 1'b0;
              state    <= EXPAND;
            end
          end
        end
        EXPAND: begin
          if (!start_key_exp) begin
            state <= IDLE;
            round <= 4'd0;
          end else begin
            rk[round] <= {n0, n1, n2, n3};
            if (last_round) begin
              state    <= DONE;
              rk_valid <= 1'b1;
              round    <= 4'd0;
            end else begin
              round <= round + 4'd1;
            end
          end
        end
        DONE: state <= WAIT_LOW;
        default: begin
          // DCU holds the request until it has seen key_expanded; wait for the drop
          if (!start_key_exp)
            state <= IDLE;
        end
      endcase
    end
  end

  assign busy         = (state == EXPAND);
  assign key_expanded = (state == DONE);

  always_comb begin
    rk_out = '0;
    if (rk_sel <= 4'(NROUNDS))
      rk_out = rk[rk_sel];
  end

endmodule

// File: tb/tb_key_expander.sv
// tb/tb_key_expander.sv - scoreboard bench for key_expander with FIPS-197 directed vectors
// Honours KEY_CACHE_EN to select the expected cached-request latency.

module tb_key_expander;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_A = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B = 128'h97049427aad9b15464867349d2da88aa;
`ifdef KEY_CACHE_EN
  localparam int REPEAT_LAT = 1;
`else
  localparam int REPEAT_LAT = 11;
`endif

  localparam int SIG_RK    = 0;
  localparam int SIG_VALID = 1;
  localparam int SIG_BUSY  = 2;
  localparam int SIG_DONE  = 3;

  logic         tb_clk = 1'b0;
  logic         rst;
  logic         start_key_exp;
  logic [127:0] key_in;
  logic [3:0]   rk_sel;
  logic [127:0] rk_out;
  logic         key_expanded;
  logic         rk_valid;
  logic         busy;

  typedef struct {
    string        name;
    int           sig;
    logic [127:0] exp;
  } chk_t;

  chk_t chk_q[$];
  int   pulse_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  key_expander dut (
    .clk          (tb_clk),
    .rst          (rst),
    .start_key_exp(start_key_exp),
    .key_in       (key_in),
    .rk_sel       (rk_sel),
    .rk_out       (rk_out),
    .key_expanded (key_expanded),
    .rk_valid     (rk_valid),
    .busy         (busy)
  );

  always #5 tb_clk = ~tb_clk;

  always @(posedge tb_clk) cyc <= cyc + 1;

  // Monitor: drains pending level checks and matches completion pulses against expected cycles
  always @(negedge tb_clk) begin
    logic [127:0] act;
    int           e;
    while (chk_q.size() > 0) begin
      chk_t c;
      c = chk_q.pop_front();
      case (c.sig)
        SIG_RK:    act = rk_out;
        SIG_VALID: act = {127'b0, rk_valid};
        SIG_BUSY:  act = {127'b0, busy};
        default:   act = {127'b0, key_expanded};
      endcase
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", c.name, act, c.exp, cyc);
      end
    end
    if (key_expanded) begin
      checks++;
      if (pulse_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_key_expanded: pulse at cycle %0d, none expected", cyc);
      end else begin
        e = pulse_q.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL pulse_latency: pulse at cycle %0d expected cycle %0d", cyc, e);
        end
      end
    end else if (pulse_q.size() > 0 && cyc > pulse_q[0]) begin
      checks++;
      errors++;
      e = pulse_q.pop_front();
      $display("FAIL missing_key_expanded: no pulse by cycle %0d expected cycle %0d", cyc, e);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge tb_clk);
    #1;
  endtask

  task automatic expect_sig(input string name, input int sig, input logic [127:0] exp);
    chk_t c;
    c.name = name;
    c.sig  = sig;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic read_chk(input int s, input logic [127:0] exp, input string name);
    rk_sel = 4'(s);
    expect_sig(name, SIG_RK, exp);
    @(negedge tb_clk);
    #1;
  endtask

  task automatic request(input logic [127:0] k, input int lat);
    key_in        = k;
    start_key_exp = 1'b1;
    pulse_q.push_back(cyc + lat);
  endtask

  initial begin
    rst           = 1'b1;
    start_key_exp = 1'b0;
    key_in        = '0;
    rk_sel        = 4'd0;
    tick(2);
    rst = 1'b0;
    expect_sig("reset_busy", SIG_BUSY, 128'd0);
    expect_sig("reset_rk_valid", SIG_VALID, 128'd0);
    expect_sig("reset_key_expanded", SIG_DONE, 128'd0);
    expect_sig("reset_rk0", SIG_RK, 128'd0);
    tick(1);

    // FIPS-197 vector with out-of-range reads in EXPAND, DONE and WAIT_LOW
    request(KEY_A, 11);
    tick(1);
    rk_sel = 4'd12;
    expect_sig("oor_expand", SIG_RK, 128'd0);
    expect_sig("busy_expand", SIG_BUSY, 128'd1);
    tick(10);
    rk_sel = 4'd13;
    expect_sig("oor_done", SIG_RK, 128'd0);
    expect_sig("rk_valid_done", SIG_VALID, 128'd1);
    expect_sig("busy_done", SIG_BUSY, 128'd0);
    tick(1);
    read_chk(1, RK1_A, "fips_rk1");
    read_chk(10, RK10_A, "fips_rk10");
    read_chk(11, 128'd0, "oor_wait_11");
    read_chk(15, 128'd0, "oor_wait_15");
    read_chk(0, KEY_A, "fips_rk0");

    // Hold-high: no retrigger while the request stays up
    tick(3);
    expect_sig("hold_busy", SIG_BUSY, 128'd0);
    expect_sig("hold_rk_valid", SIG_VALID, 128'd1);
    start_key_exp = 1'b0;
    tick(2);
    request(KEY_B, 11);
    tick(12);
    read_chk(0, KEY_B, "second_rk0");
    start_key_exp = 1'b0;
    tick(2);

    // Repeat of the same key, then a different key
    request(KEY_B, REPEAT_LAT);
    tick(12);
    start_key_exp = 1'b0;
    tick(2);
    request(KEY_A, 11);
    tick(12);
    read_chk(10, RK10_A, "new_key_rk10");
    start_key_exp = 1'b0;
    tick(2);

    // Abort at round 4
    key_in        = KEY_B;
    start_key_exp = 1'b1;
    tick(4);
    start_key_exp = 1'b0;
    tick(1);
    expect_sig("abort_busy", SIG_BUSY, 128'd0);
    expect_sig("abort_rk_valid", SIG_VALID, 128'd0);
    tick(2);
    request(KEY_A, 11);
    tick(12);
    read_chk(10, RK10_A, "after_abort_rk10");
    read_chk(1, RK1_A, "after_abort_rk1");
    start_key_exp = 1'b0;
    tick(2);

    // Reset at round 6
    key_in        = KEY_B;
    start_key_exp = 1'b1;
    tick(6);
    rst           = 1'b1;
    start_key_exp = 1'b0;
    tick(1);
    expect_sig("rst_busy", SIG_BUSY, 128'd0);
    expect_sig("rst_rk_valid", SIG_VALID, 128'd0);
    expect_sig("rst_key_expanded", SIG_DONE, 128'd0);
    for (int s = 0; s < 16; s++)
      read_chk(s, 128'd0, $sformatf("rst_rk%0d", s));
    rst = 1'b0;
    tick(3);

    checks++;
    if (pulse_q.size() != 0) begin
      errors++;
      $display("FAIL pending_pulses: %0d outstanding expected 0", pulse_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_expander.md
Name: key_expander

Overview:
- AES-128 key-schedule engine serving the decryption controller (DCU).
- On DCU's start_key_exp request it expands the loaded 128-bit key into 11 round keys, one round key per clock, and holds them in an internal table.
- Signals completion on key_expanded.
- The round engine reads the table in any order through a random-access read port; decryption reads it from round 10 down to round 0.

Parameters:
- NROUNDS, 10, number of expansion rounds; fixed at 10 for AES-128, so the table holds NROUNDS+1 entries.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start_key_exp  in  1  expansion request from the DCU; level, held high until key_expanded is seen.
- key_in  in  128  cipher key (DCU d_key); byte 0 = key_in[127:120].
- rk_sel  in  4  round-key read index, 0..10.
- rk_out  out  128  round key at rk_sel; combinational read of the table.
- key_expanded  out  1  one-cycle completion pulse.
- rk_valid  out  1  table holds a complete schedule.
- busy  out  1  expansion in progress.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. When rst=1 at a clk edge:
  - state=IDLE, round counter=0.
  - All 11 table entries=0.
  - key_expanded=0, rk_valid=0, busy=0.
  - rst overrides every other input, including mid-expansion.
- IDLE:
  - start_key_exp=1 -> write key_in to rk[0], round=1, clear rk_valid, go to EXPAND.
- EXPAND (busy=1):
  - Each cycle, with prev=rk[round-1] split into words w0..w3 (w0=[127:96]):
    - t = SubWord(RotWord(w3)) XOR {rcon[round],24'h0}.
    - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2; rk[round]={n0,n1,n2,n3}; round++.
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
  - SubWord uses four instances of the codebase's byte sbox module.
  - After writing rk[10], go to DONE.
  - start_key_exp=0 during EXPAND -> abort: go to IDLE, rk_valid stays 0, partially written entries are don't-care.
- DONE (1 cycle):
  - key_expanded=1, rk_valid=1, busy=0, then go to WAIT_LOW.
- WAIT_LOW:
  - Stay while start_key_exp=1; go to IDLE when it is 0.
  - This prevents re-triggering, because the DCU drops start_key_exp only after it has sampled key_expanded.
- Latency: start_key_exp sampled at edge E0 -> rk[0] loaded at E0, rk[10] written at E10, key_expanded high during the cycle after E10 (11 cycles after the request edge).
- rk_sel > 10 -> rk_out=0.
- Reads during EXPAND return the current table contents; no stall.
- key_in is sampled only at the IDLE->EXPAND edge; later changes are ignored.

Optional Feature:
- Macro: KEY_CACHE_EN.
- Defined:
  - A 128-bit register holds the last fully expanded key.
  - In IDLE, if start_key_exp=1, rk_valid=1 and key_in equals the cached key, skip EXPAND: go directly to DONE, so key_expanded pulses in the cycle after the request edge.
  - The cache is cleared by reset and by an abort.
- Undefined: every request runs the full 10-round expansion.

Test Plan:
1. FIPS-197 vector:
   - key_in=2b7e151628aed2a6abf7158809cf4f3c, start_key_exp held high.
   - key_expanded pulses exactly 11 cycles after the request edge, for one cycle.
   - rk_sel=1 -> a0fafe1788542cb123a339392a6c7605.
   - rk_sel=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
   - rk_valid=1.
2. Hold-high:
   - Keep start_key_exp=1 for 5 cycles after key_expanded.
   - No second key_expanded pulse; busy=0.
   - Drop start_key_exp, then raise it with key_in=97049427aad9b15464867349d2da88aa.
   - A new expansion runs; rk_sel=0 returns that key.
3. Abort:
   - Drop start_key_exp at round 4.
   - State returns to IDLE, rk_valid=0, no key_expanded pulse.
   - A following full request completes normally.
4. Reset mid-operation:
   - rst=1 at round 6.
   - Next cycle: busy=0, rk_valid=0, rk_out=0 for every rk_sel.
5. Out-of-range read: rk_sel=11..15 -> rk_out=0 in every state.
6. KEY_CACHE_EN:
   - Repeat the request with the same key -> key_expanded 1 cycle after the request edge.
   - A different key -> full 11-cycle latency.
   - Macro undefined -> both requests take 11 cycles.
